jt12_slot_seq: RTL and testbench

- Registered slot sequencer and decoder for the FM operator pipeline.
- Owns the current {op[1:0], ch[2:0]} slot register and advances it once per clock-enable, using the codebase channel-skip encoding.
- Decodes the current slot into a linear index, a one-hot operator, and frame strobes.
- Provides a programmable-delay copy of the slot code for downstream pipeline stages.

---
 rtl/jt12_slot_pkg.sv | 22 ++
 rtl/jt12_slot_dec.sv | 36 +++
 rtl/jt12_slot_seq.sv | 119 +++++++++++
 tb/tb_jt12_slot_seq.sv | 139 +++++++++++++
 4 files changed

// File: rtl/jt12_slot_pkg.sv
// jt12_slot_pkg: shared constants for the FM operator slot sequencer.
//   Slot code is {op[1:0], ch[2:0]}. With six channels the channel code
//   skips 3 (codes 0,1,2,4,5,6); with three channels it runs 0,1,2.
package jt12_slot_pkg;

  localparam int OPW   = 2;
  localparam int CHW   = 3;
  localparam int SLOTW = OPW + CHW;

  localparam logic [SLOTW-1:0] LAST_SLOT6 = 5'b11110;  // {3,6}
  localparam logic [SLOTW-1:0] LAST_SLOT3 = 5'b11010;  // {3,2}

  localparam logic [CHW-1:0] SKIP_CH = 3'd3;

  localparam int FRAME6 = 24;
  localparam int FRAME3 = 12;

  function automatic logic [SLOTW-1:0] last_slot(input int num_ch);
    return (num_ch == 3) ? LAST_SLOT3 : LAST_SLOT6;
  endfunction

endpackage

// File: rtl/jt12_slot_dec.sv
// jt12_slot_dec: combinational decode of a {op,ch} slot code.
//   slot  in  5  slot code {op,ch}
//   lin   out 5  linear index op*NUM_CH + channel index
//   op_oh out 4  one-hot operator
//   zero  out 1  slot == 0
//   last  out 1  slot is the final slot of the frame
module jt12_slot_dec
  import jt12_slot_pkg::*;
#(
  parameter int NUM_CH = 6
) (
  input  logic [4:0] slot,
  output logic [4:0] lin,
  output logic [3:0] op_oh,
  output logic       zero,
  output logic       last
);

  logic [OPW-1:0] op;
  logic [CHW-1:0] ch;
  logic [CHW-1:0] chidx;

  assign op = slot[4:3];
  assign ch = slot[2:0];

  always_comb begin
    chidx = ch;
    // Six-channel codes 4..6 sit one above their index because code 3 is skipped.
    if (NUM_CH == 6) chidx = ch - {2'b00, ch[2]};
    lin   = 5'(op) * 5'(NUM_CH) + {2'b00, chidx};
    op_oh = 4'b0001 << op;
    zero  = (slot == 5'd0);
    last  = (slot == last_slot(NUM_CH));
  end

endmodule

// File: rtl/jt12_slot_seq.sv
// jt12_slot_seq: registered slot sequencer and decoder for the FM operator pipeline.
//   clk      in  1  system clock
//   rst_n    in  1  synchronous active-low reset
//   cen      in  1  clock enable, one slot advance per enabled cycle
//   sync_req in  1  realign sequence to slot 0 (held pending until next cen)
//   slot     out 5  current slot {op,ch}
//   lin      out 5  linear slot index
//   op_oh    out 4  one-hot operator
//   zero     out 1  slot == 0
//   last     out 1  final slot of the frame
//   slot_dly out 5  slot from DLY enabled cycles earlier
//   err      out 1  sticky illegal-slot flag
// Optional: define JT12_SLOT_CHECK_EN to build the illegal-slot check; without
// it err is tied 0 and illegal codes advance like any other.
module jt12_slot_seq
  import jt12_slot_pkg::*;
#(
  parameter int NUM_CH = 6,
  parameter int DLY    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       sync_req,
  output logic [4:0] slot,
  output logic [4:0] lin,
  output logic [3:0] op_oh,
  output logic       zero,
  output logic       last,
  output logic [4:0] slot_dly,
  output logic       err
);

  logic [OPW-1:0] op;
  logic [CHW-1:0] ch;
  logic [4:0]     slot_adv;
  logic [4:0]     slot_nxt;
  logic           sync_pend;
  logic           illegal;
  logic           load_zero;
  logic [4:0]     lin_nxt;
  logic [3:0]     op_oh_nxt;
  logic           zero_nxt;
  logic           last_nxt;
  logic [4:0]     dly_p [DLY];

  assign op = slot[4:3];
  assign ch = slot[2:0];

`ifdef JT12_SLOT_CHECK_EN
  always_comb begin
    illegal = 1'b0;
    if (NUM_CH == 6) illegal = (ch == SKIP_CH) || (ch == 3'd7);
    else             illegal = (ch > 3'd2);
  end
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    slot_adv = {op, ch + 3'd1};
    if (NUM_CH == 6) begin
      if (ch == 3'd6)                 slot_adv = {op + 2'd1, 3'd0};
      else if (ch + 3'd1 == SKIP_CH)  slot_adv = {op, SKIP_CH + 3'd1};
    end else begin
      if (ch == 3'd2)                 slot_adv = {op + 2'd1, 3'd0};
    end
    load_zero = sync_req | sync_pend | illegal;
    slot_nxt  = slot;
    if (cen) slot_nxt = load_zero ? 5'd0 : slot_adv;
  end

  // Decode the next value so the decoded outputs register together with slot.
  jt12_slot_dec #(.NUM_CH(NUM_CH)) u_dec (
    .slot  (slot_nxt),
    .lin   (lin_nxt),
    .op_oh (op_oh_nxt),
    .zero  (zero_nxt),
    .last  (last_nxt)
  );

  // ---- slot register, decode register, sync pending, delay line ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot      <= 5'd0;
      lin       <= 5'd0;
      op_oh     <= 4'b0001;
      zero      <= 1'b1;
      last      <= 1'b0;
      sync_pend <= 1'b0;
      for (int i = 0; i < DLY; i++) dly_p[i] <= 5'd0;
    end else begin
      slot  <= slot_nxt;
      lin   <= lin_nxt;
      op_oh <= op_oh_nxt;
      zero  <= zero_nxt;
      last  <= last_nxt;
      if (cen) begin
        sync_pend <= 1'b0;
        dly_p[0]  <= slot;
        for (int i = 1; i < DLY; i++) dly_p[i] <= dly_p[i-1];
      end else if (sync_req) begin
        sync_pend <= 1'b1;
      end
    end
  end

  assign slot_dly = dly_p[DLY-1];

`ifdef JT12_SLOT_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)              err <= 1'b0;
    else if (cen && illegal) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jt12_slot_seq.sv
module tb_jt12_slot_seq;

  logic       clk = 1'b0;
  logic       rst_n, cen, sync_req;
  logic [4:0] slot6, lin6, dly6, slot3, lin3, dly3;
  logic [3:0] oh6, oh3;
  logic       zero6, last6, err6, zero3, last3, err3;

  int errors = 0;
  int checks = 0;
  int seq6 [24];
  int seq3 [12];
  int ch6tab [6];
  int p;
  logic [4:0] held, held_dly;

  always #5 clk = ~clk;

  jt12_slot_seq #(.NUM_CH(6), .DLY(2)) dut6 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .sync_req(sync_req),
    .slot(slot6), .lin(lin6), .op_oh(oh6), .zero(zero6), .last(last6),
    .slot_dly(dly6), .err(err6));

  jt12_slot_seq #(.NUM_CH(3), .DLY(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .sync_req(sync_req),
    .slot(slot3), .lin(lin3), .op_oh(oh3), .zero(zero3), .last(last3),
    .slot_dly(dly3), .err(err3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ch6tab = '{0, 1, 2, 4, 5, 6};
    for (int i = 0; i < 24; i++) seq6[i] = (i / 6) * 8 + ch6tab[i % 6];
    for (int i = 0; i < 12; i++) seq3[i] = (i / 3) * 8 + (i % 3);

    rst_n = 1'b0; cen = 1'b1; sync_req = 1'b0;
    step(); step();
    check("rst_slot", slot6, 0);
    check("rst_lin", lin6, 0);
    check("rst_op_oh", oh6, 4'b0001);
    check("rst_zero", zero6, 1);
    check("rst_last", last6, 0);
    check("rst_dly", dly6, 0);
    check("rst_err", err6, 0);
    check("rst_slot3", slot3, 0);

    // Continuous advance: 24 slots for six channels, 12 for three.
    rst_n = 1'b1; cen = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      check("adv6_slot", slot6, seq6[i % 24]);
      check("adv6_lin", lin6, i % 24);
      check("adv6_op_oh", oh6, 4'b0001 << ((i % 24) / 6));
      check("adv6_last", last6, (i % 24) == 23);
      check("adv6_zero", zero6, (i % 24) == 0);
      check("adv6_dly", dly6, (i >= 2) ? seq6[(i - 2) % 24] : 0);
      if (i <= 13) begin
        check("adv3_slot", slot3, seq3[i % 12]);
        check("adv3_lin", lin3, i % 12);
        check("adv3_last", last3, (i % 12) == 11);
      end
    end
    check("err_quiet", err6, 0);
    p = 24;

    // Enable every third clock; outputs hold in between.
    for (int k = 0; k < 6; k++) begin
      held = slot6; held_dly = dly6;
      cen = 1'b0;
      step(); step();
      check("gap_hold_slot", slot6, held);
      check("gap_hold_dly", dly6, held_dly);
      cen = 1'b1;
      step();
      p++;
      check("gap_slot", slot6, seq6[p % 24]);
      check("gap_dly", dly6, seq6[(p - 2) % 24]);
    end

    // Advance to lin 13, then sync together with cen.
    while ((p % 24) != 13) begin step(); p++; end
    check("pre_sync_lin", lin6, 13);
    sync_req = 1'b1;
    step();
    sync_req = 1'b0;
    check("sync_slot", slot6, 0);
    check("sync_lin", lin6, 0);
    check("sync_zero", zero6, 1);
    check("sync_dly", dly6, seq6[12]);
    step(); step(); step();
    check("post_sync_slot", slot6, seq6[3]);

    // Pending sync: request without cen, enable three clocks later.
    cen = 1'b0; sync_req = 1'b1;
    step();
    sync_req = 1'b0;
    step(); step();
    check("pend_hold", slot6, seq6[3]);
    cen = 1'b1;
    step();
    check("pend_slot", slot6, 0);
    step();
    check("pend_after", slot6, seq6[1]);

    // Reset mid-frame at lin 17 with cen active.
    for (int i = 2; i <= 17; i++) step();
    check("pre_rst_lin", lin6, 17);
    rst_n = 1'b0;
    step();
    check("mid_rst_slot", slot6, 0);
    check("mid_rst_lin", lin6, 0);
    check("mid_rst_zero", zero6, 1);
    check("mid_rst_dly", dly6, 0);
    rst_n = 1'b1;
    step();
    check("resume_slot", slot6, seq6[1]);
    check("resume_lin", lin6, 1);
    check("resume_dly", dly6, 0);
    step();
    check("resume_dly2", dly6, 0);
    step();
    check("resume_dly3", dly6, seq6[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
